hwpe_multi_cfg_ctrl: RTL and testbench

Configuration-side front end for a cluster hosting N_HWPE accelerators behind one peripheral config slave port. Decodes the config address to select one HWPE and forwards the request. Tracks the single outstanding response and returns it with its ID. Per HWPE, counts queued/running jobs to produce real busy flags, replacing the constant busy=1, and OR-merges the per-core event lines of all HWPEs.

---
 rtl/hwpe_multi_cfg_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_hwpe_multi_cfg_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_multi_cfg_ctrl.sv
// Config-side front end for N_HWPE accelerators behind one peripheral config slave port.
// Latency: a granted access answers 1 cycle after the HWPE response; out-of-range accesses answer the cycle after grant.
// Backpressure: one outstanding access; cfg_gnt_o stays low until the previous response has been returned.
//
// Ports:
//   clk, rst_n                  cluster clock, asynchronous active-low reset
//   cfg_*_i / cfg_*_o           peripheral config slave (req/gnt, r_valid/r_rdata/r_id)
//   hwpe_req_o, hwpe_add_o ...  one-hot request plus broadcast address/data to the HWPEs
//   hwpe_gnt_i, hwpe_r_*_i      per-HWPE grant and response
//   hwpe_evt_i / evt_o          per-HWPE per-core events, OR-merged over all HWPEs
//   hwpe_busy_o, busy_o         per-HWPE job-count based busy and their OR
//   hwpe_clk_en_o               per-HWPE clock enable (idle hold only with macro HWPE_CLK_GATE_EN)
module hwpe_multi_cfg_ctrl #(
  parameter int N_HWPE       = 2,
  parameter int N_CORES      = 8,
  parameter int ID_WIDTH     = 8,
  parameter int HWPE_SEL_LSB = 8,
  parameter int TRIGGER_OFFS = 0,
  parameter int JOB_DEPTH    = 2,
  parameter int CG_HOLD      = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    cfg_req_i,
  input  logic [31:0]                             cfg_add_i,
  input  logic                                    cfg_wen_i,
  input  logic [3:0]                              cfg_be_i,
  input  logic [31:0]                             cfg_wdata_i,
  input  logic [ID_WIDTH-1:0]                     cfg_id_i,
  output logic                                    cfg_gnt_o,
  output logic [31:0]                             cfg_r_rdata_o,
  output logic                                    cfg_r_valid_o,
  output logic [ID_WIDTH-1:0]                     cfg_r_id_o,
  output logic [N_HWPE-1:0]                       hwpe_req_o,
  output logic [31:0]                             hwpe_add_o,
  output logic                                    hwpe_wen_o,
  output logic [3:0]                              hwpe_be_o,
  output logic [31:0]                             hwpe_data_o,
  output logic [ID_WIDTH-1:0]                     hwpe_id_o,
  input  logic [N_HWPE-1:0]                       hwpe_gnt_i,
  input  logic [N_HWPE-1:0][31:0]                 hwpe_r_data_i,
  input  logic [N_HWPE-1:0]                       hwpe_r_valid_i,
  input  logic [N_HWPE-1:0][ID_WIDTH-1:0]         hwpe_r_id_i,
  input  logic [N_HWPE-1:0][N_CORES-1:0][1:0]     hwpe_evt_i,
  output logic [N_CORES-1:0][1:0]                 evt_o,
  output logic [N_HWPE-1:0]                       hwpe_busy_o,
  output logic                                    busy_o,
  output logic [N_HWPE-1:0]                       hwpe_clk_en_o
);

  localparam int SEL_W = (N_HWPE > 1) ? $clog2(N_HWPE) : 1;
  localparam int CNT_W = $clog2(JOB_DEPTH + 1);
  localparam int UP_W  = 32 - HWPE_SEL_LSB;

  typedef enum logic [1:0] {IDLE, WAIT_RESP, ERR_RESP} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel, sel_q;
  logic                in_range, is_trig, acc_grant, trig_ok;
  logic                r_valid_q;
  logic [31:0]         r_rdata_q;
  logic [ID_WIDTH-1:0] r_id_q;
  logic [N_HWPE-1:0]   dec;

  assign sel = cfg_add_i[HWPE_SEL_LSB +: SEL_W];
  // The range test looks at the whole upper address field, so an address whose
  // low select bits alias a valid HWPE but whose upper bits do not is still rejected.
  assign in_range  = (cfg_add_i[31:HWPE_SEL_LSB] < UP_W'(N_HWPE));
  assign is_trig   = (cfg_add_i[HWPE_SEL_LSB-1:0] == HWPE_SEL_LSB'(TRIGGER_OFFS));
  assign acc_grant = (state_q == IDLE) && cfg_req_i && in_range && hwpe_gnt_i[sel];
  assign trig_ok   = acc_grant && !cfg_wen_i && is_trig;

  assign hwpe_add_o  = cfg_add_i;
  assign hwpe_wen_o  = cfg_wen_i;
  assign hwpe_be_o   = cfg_be_i;
  assign hwpe_data_o = cfg_wdata_i;
  assign hwpe_id_o   = cfg_id_i;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state. WAIT_RESP is left only after the response pulse has been
  // shown, which gives the 3-cycle grant spacing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_req_i) begin
          if (!in_range)      state_d = ERR_RESP;
          else if (acc_grant) state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: if (r_valid_q) state_d = IDLE;
      ERR_RESP:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    hwpe_req_o = '0;
    cfg_gnt_o  = 1'b0;
    if (state_q == IDLE && cfg_req_i) begin
      if (in_range) begin
        hwpe_req_o[sel] = 1'b1;
        cfg_gnt_o       = hwpe_gnt_i[sel];
      end else begin
        cfg_gnt_o = 1'b1;
      end
    end
  end

  // Response capture: the error response is produced straight from the grant
  // cycle; a normal response is taken once from the selected HWPE only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      r_valid_q <= 1'b0;
      r_rdata_q <= '0;
      r_id_q    <= '0;
    end else begin
      r_valid_q <= 1'b0;
      if (acc_grant) sel_q <= sel;
      if (state_q == IDLE && cfg_req_i && !in_range) begin
        r_valid_q <= 1'b1;
        r_rdata_q <= '0;
        r_id_q    <= cfg_id_i;
      end
      if (state_q == WAIT_RESP && !r_valid_q && hwpe_r_valid_i[sel_q]) begin
        r_valid_q <= 1'b1;
        r_rdata_q <= hwpe_r_data_i[sel_q];
        r_id_q    <= hwpe_r_id_i[sel_q];
      end
    end
  end

  assign cfg_r_valid_o = r_valid_q;
  assign cfg_r_rdata_o = r_rdata_q;
  assign cfg_r_id_o    = r_id_q;

  always_comb begin
    evt_o = '0;
    dec   = '0;
    for (int h = 0; h < N_HWPE; h++) begin
      evt_o = evt_o | hwpe_evt_i[h];
      for (int c = 0; c < N_CORES; c++) dec[h] = dec[h] | hwpe_evt_i[h][c][0];
    end
  end

  // Per-HWPE job counter; end-of-job from any core counts once per cycle.
  for (genvar h = 0; h < N_HWPE; h++) begin : g_job
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc, busy_q;
    assign inc = trig_ok && (sel == SEL_W'(h));
    always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec[h] && cnt_q != CNT_W'(JOB_DEPTH)) cnt_d = cnt_q + 1'b1;
      else if (dec[h] && !inc && cnt_q != '0)           cnt_d = cnt_q - 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        busy_q <= (cnt_d != '0);
      end
    end
    assign hwpe_busy_o[h] = busy_q;
  end

  assign busy_o = |hwpe_busy_o;

`ifdef HWPE_CLK_GATE_EN
  localparam int HOLD_W = $clog2(CG_HOLD + 1);
  for (genvar h = 0; h < N_HWPE; h++) begin : g_cg
    logic [HOLD_W-1:0] hold_q;
    logic              tgt_now, tgt_act;
    assign tgt_now = cfg_req_i && (sel == SEL_W'(h));
    assign tgt_act = (state_q != IDLE) && (sel_q == SEL_W'(h));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hold_q <= '0;
      else if (hwpe_busy_o[h] || (state_q == IDLE && tgt_now) ||
               (state_q == WAIT_RESP && sel_q == SEL_W'(h)))
        hold_q <= HOLD_W'(CG_HOLD);
      else if (hold_q != '0)
        hold_q <= hold_q - 1'b1;
    end
    assign hwpe_clk_en_o[h] = hwpe_busy_o[h] | tgt_now | tgt_act | (hold_q != '0);
  end
`else
  assign hwpe_clk_en_o = '1;
`endif

endmodule

// File: tb/tb_hwpe_multi_cfg_ctrl.sv
// Self-checking bench for hwpe_multi_cfg_ctrl (N_HWPE=2, N_CORES=8, JOB_DEPTH=2).
// Decode/event table, scoreboarded config accesses, job counting, reset and clock-enable sequences.
module tb_hwpe_multi_cfg_ctrl;
  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cfg_req = 1'b0;
  logic [31:0]           cfg_add = '0;
  logic                  cfg_wen = 1'b0;
  logic [3:0]            cfg_be = 4'hF;
  logic [31:0]           cfg_wdata = '0;
  logic [7:0]            cfg_id = '0;
  logic                  cfg_gnt;
  logic [31:0]           cfg_r_rdata;
  logic                  cfg_r_valid;
  logic [7:0]            cfg_r_id;
  logic [1:0]            hwpe_req;
  logic [31:0]           hwpe_add;
  logic                  hwpe_wen;
  logic [3:0]            hwpe_be;
  logic [31:0]           hwpe_data;
  logic [7:0]            hwpe_id;
  logic [1:0]            hwpe_gnt = '0;
  logic [1:0][31:0]      hwpe_r_data = '0;
  logic [1:0]            hwpe_r_valid = '0;
  logic [1:0][7:0]       hwpe_r_id = '0;
  logic [1:0][7:0][1:0]  hwpe_evt = '0;
  logic [7:0][1:0]       evt;
  logic [1:0]            hwpe_busy;
  logic                  busy;
  logic [1:0]            hwpe_clk_en;

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  id;
  } resp_t;
  resp_t sbq[$];
  resp_t exp_r;

  typedef struct {
    logic        req;
    logic [31:0] add;
    logic [1:0]  gnt;
    logic [31:0] evt;
    logic [1:0]  exp_req;
    logic        exp_gnt;
    logic [15:0] exp_evt;
  } vec_t;
  vec_t vecs[9];

  hwpe_multi_cfg_ctrl #(
    .N_HWPE(2), .N_CORES(8), .ID_WIDTH(8), .HWPE_SEL_LSB(8),
    .TRIGGER_OFFS(0), .JOB_DEPTH(2), .CG_HOLD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_req_i(cfg_req), .cfg_add_i(cfg_add), .cfg_wen_i(cfg_wen), .cfg_be_i(cfg_be),
    .cfg_wdata_i(cfg_wdata), .cfg_id_i(cfg_id),
    .cfg_gnt_o(cfg_gnt), .cfg_r_rdata_o(cfg_r_rdata), .cfg_r_valid_o(cfg_r_valid), .cfg_r_id_o(cfg_r_id),
    .hwpe_req_o(hwpe_req), .hwpe_add_o(hwpe_add), .hwpe_wen_o(hwpe_wen), .hwpe_be_o(hwpe_be),
    .hwpe_data_o(hwpe_data), .hwpe_id_o(hwpe_id),
    .hwpe_gnt_i(hwpe_gnt), .hwpe_r_data_i(hwpe_r_data), .hwpe_r_valid_i(hwpe_r_valid),
    .hwpe_r_id_i(hwpe_r_id), .hwpe_evt_i(hwpe_evt),
    .evt_o(evt), .hwpe_busy_o(hwpe_busy), .busy_o(busy), .hwpe_clk_en_o(hwpe_clk_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every response must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && cfg_r_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_resp: got rdata 0x%0h id 0x%0h expected no response", cfg_r_rdata, cfg_r_id);
      end else begin
        exp_r = sbq.pop_front();
        chk("resp_rdata", cfg_r_rdata, exp_r.d);
        chk("resp_id", cfg_r_id, exp_r.id);
      end
    end
  end

  // One config access; the addressed HWPE grants at once and answers the next
  // cycle, while the other HWPE raises a spurious response that must be ignored.
  task automatic access(input logic [31:0] add, input logic wen, input logic [7:0] id,
                        input logic [31:0] hdata, input logic evt_in_grant);
    logic inr;
    int   s;
    resp_t e;
    inr = (add[31:8] < 24'd2);
    s   = int'(add[8]);
    @(posedge clk); #1;
    cfg_req = 1'b1; cfg_add = add; cfg_wen = wen; cfg_id = id; cfg_wdata = 32'h1234_5678;
    if (inr) hwpe_gnt[s] = 1'b1;
    if (evt_in_grant) hwpe_evt[0][5][0] = 1'b1;
    e.d = inr ? hdata : 32'h0;
    e.id = id;
    sbq.push_back(e);
    @(negedge clk);
    chk("acc_hwpe_req", hwpe_req, inr ? (2'b01 << s) : 2'b00);
    chk("acc_gnt", cfg_gnt, 1);
    @(posedge clk); #1;
    cfg_req = 1'b0; hwpe_gnt = '0; hwpe_evt = '0;
    if (inr) begin
      hwpe_r_valid[s] = 1'b1; hwpe_r_data[s] = hdata; hwpe_r_id[s] = id;
      hwpe_r_valid[1-s] = 1'b1; hwpe_r_data[1-s] = 32'hDEAD_BEEF; hwpe_r_id[1-s] = 8'hEE;
    end
    @(negedge clk);
    chk("acc_req_idle", hwpe_req, 0);
    chk("acc_rvalid_c1", cfg_r_valid, inr ? 1'b0 : 1'b1);
    @(posedge clk); #1;
    hwpe_r_valid = '0;
    @(negedge clk);
    chk("acc_rvalid_c2", cfg_r_valid, inr ? 1'b1 : 1'b0);
    chk("acc_gnt_blocked", cfg_gnt, 0);
    @(posedge clk);
    @(negedge clk);
    chk("acc_rvalid_c3", cfg_r_valid, 0);
  endtask

  task automatic end_event();
    @(posedge clk); #1;
    hwpe_evt[0][5][0] = 1'b1;
    @(posedge clk); #1;
    hwpe_evt = '0;
  endtask

  initial begin
    //          req  add           gnt    evt            exp_req exp_gnt exp_evt
    vecs[0] = '{1'b0, 32'h0000_0104, 2'b11, 32'h0,         2'b00, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 32'h0000_0004, 2'b00, 32'h0,         2'b01, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 32'h0000_0104, 2'b01, 32'h0,         2'b10, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 32'h0000_010C, 2'b10, 32'h0,         2'b10, 1'b1, 16'h0000};
    vecs[4] = '{1'b1, 32'h0000_0004, 2'b01, 32'h0002_0001, 2'b01, 1'b1, 16'h0003};
    vecs[5] = '{1'b1, 32'h0000_0300, 2'b11, 32'h0,         2'b00, 1'b1, 16'h0000};
    vecs[6] = '{1'b1, 32'h0000_0200, 2'b11, 32'h0,         2'b00, 1'b1, 16'h0000};
    vecs[7] = '{1'b0, 32'h0000_0000, 2'b00, 32'h8000_4000, 2'b00, 1'b0, 16'hC000};
    vecs[8] = '{1'b0, 32'h0000_0000, 2'b00, 32'h0F00_00F0, 2'b00, 1'b0, 16'h0FF0};

    // Reset state
    #12;
    chk("rst_gnt", cfg_gnt, 0);
    chk("rst_rvalid", cfg_r_valid, 0);
    chk("rst_rdata", cfg_r_rdata, 0);
    chk("rst_rid", cfg_r_id, 0);
    chk("rst_hwpe_req", hwpe_req, 0);
    chk("rst_hwpe_busy", hwpe_busy, 0);
    chk("rst_busy", busy, 0);
    #5 rst_n = 1'b1;

    // Combinational decode and event merge; requests withdrawn before the edge
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      cfg_req = vecs[i].req; cfg_add = vecs[i].add; cfg_wen = 1'b1;
      hwpe_gnt = vecs[i].gnt; hwpe_evt = vecs[i].evt;
      @(negedge clk);
      chk($sformatf("vec%0d_hwpe_req", i), hwpe_req, vecs[i].exp_req);
      chk($sformatf("vec%0d_gnt", i), cfg_gnt, vecs[i].exp_gnt);
      chk($sformatf("vec%0d_evt", i), evt, vecs[i].exp_evt);
      #1;
      cfg_req = 1'b0; hwpe_gnt = '0; hwpe_evt = '0;
    end
    chk("tbl_busy", busy, 0);

    // Normal read to HWPE1 and out-of-range read/write
    access(32'h0000_0104, 1'b1, 8'h3C, 32'hA5A5_0001, 1'b0);
    access(32'h0000_0300, 1'b1, 8'h55, 32'h0, 1'b0);
    access(32'h0000_0300, 1'b0, 8'h56, 32'h0, 1'b0);
    chk("oor_no_job", busy, 0);

    // Non-trigger write and trigger-register read do not start jobs
    access(32'h0000_0004, 1'b0, 8'h01, 32'h0, 1'b0);
    access(32'h0000_0000, 1'b1, 8'h02, 32'h0000_0777, 1'b0);
    chk("nontrig_no_job", busy, 0);

    // Saturation: three triggers, two end events clear HWPE0
    access(32'h0000_0000, 1'b0, 8'h10, 32'h0, 1'b0);
    access(32'h0000_0000, 1'b0, 8'h11, 32'h0, 1'b0);
    access(32'h0000_0000, 1'b0, 8'h12, 32'h0, 1'b0);
    chk("sat_hwpe_busy", hwpe_busy, 2'b01);
    chk("sat_busy", busy, 1);
    end_event();
    @(negedge clk);
    chk("sat_busy_after_1evt", busy, 1);
    end_event();
    @(negedge clk);
    chk("sat_busy_after_2evt", busy, 0);
`ifdef HWPE_CLK_GATE_EN
    chk("cg_en_T1", hwpe_clk_en[0], 1);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("cg_en_T%0d", k), hwpe_clk_en[0], 1);
    end
    @(negedge clk);
    chk("cg_en_T5", hwpe_clk_en[0], 0);
`else
    repeat (5) @(negedge clk);
    chk("cg_en_tied", hwpe_clk_en, 2'b11);
`endif

    // Trigger grant and end event in the same cycle with one job running
    access(32'h0000_0000, 1'b0, 8'h20, 32'h0, 1'b0);
    chk("sim_busy_before", busy, 1);
    access(32'h0000_0000, 1'b0, 8'h21, 32'h0, 1'b1);
    chk("sim_busy_after", busy, 1);
    end_event();
    @(negedge clk);
    chk("sim_busy_cleared", busy, 0);

    // Reset while waiting for a response
    access(32'h0000_0000, 1'b0, 8'h30, 32'h0, 1'b0);
    @(posedge clk); #1;
    cfg_req = 1'b1; cfg_add = 32'h0000_0104; cfg_wen = 1'b1; cfg_id = 8'h77; hwpe_gnt[1] = 1'b1;
    @(posedge clk); #1;
    cfg_req = 1'b0; hwpe_gnt = '0;
    chk("mid_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_hwpe_busy", hwpe_busy, 0);
    chk("mid_rvalid", cfg_r_valid, 0);
    chk("mid_gnt", cfg_gnt, 0);
    chk("mid_hwpe_req", hwpe_req, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    hwpe_r_valid[1] = 1'b1; hwpe_r_data[1] = 32'h0BAD_0BAD; hwpe_r_id[1] = 8'h77;
    @(posedge clk); #1;
    hwpe_r_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lost_resp_rvalid", cfg_r_valid, 0);
    end

    // Still functional afterwards
    access(32'h0000_0004, 1'b1, 8'h11, 32'h0000_600D, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
